// File: rtl/sid_multi_regbank_if.sv
// rtl/sid_multi_regbank_if.sv - 6502-style host bus bundle for sid_multi_regbank
interface sid_multi_regbank_if #(
  parameter int NUM_SIDS = 2
);
  localparam int SEL_W = (NUM_SIDS > 1) ? $clog2(NUM_SIDS) : 1;

  logic             CEb_in;
  logic             RWb_in;
  logic [4+SEL_W:0] reg_addr;
  logic [7:0]       bus_in;
  logic [7:0]       bus_out;
  logic             oe;

  modport master (output CEb_in, RWb_in, reg_addr, bus_in, input bus_out, oe);
  modport slave  (input CEb_in, RWb_in, reg_addr, bus_in, output bus_out, oe);
endinterface

// File: rtl/sid_multi_regbank.sv
// rtl/sid_multi_regbank.sv - register bank for NUM_SIDS SID cores with per-SID shadow/commit
module sid_multi_regbank #(
  parameter int NUM_SIDS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sid_multi_regbank_if.slave      bus,
  input  logic                    sample_tick,
  input  logic [8*NUM_SIDS-1:0]   osc3_rd,
  input  logic [8*NUM_SIDS-1:0]   env3_rd,
  output logic [48*NUM_SIDS-1:0]  freq_o,
  output logic [36*NUM_SIDS-1:0]  pw_o,
  output logic [24*NUM_SIDS-1:0]  ctrl_o,
  output logic [24*NUM_SIDS-1:0]  ad_o,
  output logic [24*NUM_SIDS-1:0]  sr_o,
  output logic [11*NUM_SIDS-1:0]  fc_o,
  output logic [8*NUM_SIDS-1:0]   res_filt_o,
  output logic [8*NUM_SIDS-1:0]   mode_vol_o
);
  localparam int SEL_W = (NUM_SIDS > 1) ? $clog2(NUM_SIDS) : 1;
  localparam int NREG  = 25;
  localparam logic [4:0] OFF_SYNC   = 5'd25;
  localparam logic [4:0] OFF_STATUS = 5'd26;
  localparam logic [4:0] OFF_OSC3   = 5'd27;
  localparam logic [4:0] OFF_ENV3   = 5'd28;

  logic [SYNC_STAGES-1:0] ceb_sync_q, ceb_sync_d;
  logic [SYNC_STAGES-1:0] rwb_sync_q, rwb_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   last_we_q, last_we_d;
  logic                   armed_q, armed_d;
  logic [NUM_SIDS-1:0]    shadow_en_q, shadow_en_d;
  logic [NUM_SIDS-1:0]    pending_q, pending_d;
  logic [7:0]             shadow_q [NUM_SIDS][NREG];
  logic [7:0]             shadow_d [NUM_SIDS][NREG];
  logic [7:0]             live_q   [NUM_SIDS][NREG];
  logic [7:0]             live_d   [NUM_SIDS][NREG];

  logic             ceb_s, rwb_s, we_n, wstb;
  logic [4:0]       a_off;
  logic [SEL_W-1:0] a_sel;
  logic [7:0]       w_data;

  assign ceb_s  = ceb_sync_q[SYNC_STAGES-1];
  assign rwb_s  = rwb_sync_q[SYNC_STAGES-1];
  assign we_n   = rwb_s | ceb_s;
  assign bus.oe = !ceb_s & rwb_s;
  assign wstb   = last_we_q & !we_n & armed_q;
  assign a_off  = bus.reg_addr[4:0];
  assign a_sel  = bus.reg_addr[4+SEL_W:5];

  // fill_q marks when the sync chain holds real bus samples; a CEb already low
  // across reset release must be seen high once before any strobe can fire.
  always_comb begin : bus_sync
    ceb_sync_d[0] = bus.CEb_in;
    rwb_sync_d[0] = bus.RWb_in;
    fill_d[0]     = 1'b1;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ceb_sync_d[i] = ceb_sync_q[i-1];
      rwb_sync_d[i] = rwb_sync_q[i-1];
      fill_d[i]     = fill_q[i-1];
    end
    last_we_d = we_n;
    armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & ceb_s);
  end

  always_comb begin : wdata_mask
    w_data = bus.bus_in;
    if (a_off == 5'd3 || a_off == 5'd10 || a_off == 5'd17)
      w_data = {4'h0, bus.bus_in[3:0]};
    else if (a_off == 5'd21)
      w_data = {5'h00, bus.bus_in[2:0]};
  end

  // Commit reads the pre-edge shadow, so a data write on the commit edge waits for the next one.
  always_comb begin : reg_next
    shadow_d    = shadow_q;
    live_d      = live_q;
    shadow_en_d = shadow_en_q;
    pending_d   = pending_q;
    for (int s = 0; s < NUM_SIDS; s++) begin
      if (pending_q[s] && sample_tick) begin
        live_d[s]    = shadow_q[s];
        pending_d[s] = 1'b0;
      end
      if (wstb && a_sel == SEL_W'(s)) begin
        if (a_off < 5'(NREG)) begin
          shadow_d[s][a_off] = w_data;
          if (!shadow_en_q[s])
            live_d[s][a_off] = w_data;
        end else if (a_off == OFF_SYNC) begin
          if (!bus.bus_in[0]) begin
            shadow_en_d[s] = 1'b0;
            pending_d[s]   = 1'b0;
            live_d[s]      = shadow_q[s];
          end else begin
            shadow_en_d[s] = 1'b1;
            if (bus.bus_in[1])
              pending_d[s] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ceb_sync_q  <= '1;
      rwb_sync_q  <= '1;
      fill_q      <= '0;
      last_we_q   <= 1'b1;
      armed_q     <= 1'b0;
      shadow_en_q <= '0;
      pending_q   <= '0;
      for (int s = 0; s < NUM_SIDS; s++) begin
        for (int r = 0; r < NREG; r++) begin
          shadow_q[s][r] <= 8'h00;
          live_q[s][r]   <= 8'h00;
        end
      end
    end else begin
      ceb_sync_q  <= ceb_sync_d;
      rwb_sync_q  <= rwb_sync_d;
      fill_q      <= fill_d;
      last_we_q   <= last_we_d;
      armed_q     <= armed_d;
      shadow_en_q <= shadow_en_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      live_q      <= live_d;
    end
  end

  always_comb begin : read_mux
    bus.bus_out = 8'h00;
    for (int s = 0; s < NUM_SIDS; s++) begin
      if (a_sel == SEL_W'(s)) begin
        if (a_off < 5'(NREG))
          bus.bus_out = shadow_q[s][a_off];
        else if (a_off == OFF_STATUS)
          bus.bus_out = {6'b0, pending_q[s], shadow_en_q[s]};
        else if (a_off == OFF_OSC3)
          bus.bus_out = osc3_rd[8*s +: 8];
        else if (a_off == OFF_ENV3)
          bus.bus_out = env3_rd[8*s +: 8];
      end
    end
  end

  for (genvar s = 0; s < NUM_SIDS; s++) begin : g_sid
    for (genvar v = 0; v < 3; v++) begin : g_voice
      assign freq_o[48*s+16*v +: 16] = {live_q[s][7*v+1], live_q[s][7*v]};
      assign pw_o[36*s+12*v +: 12]   = {live_q[s][7*v+3][3:0], live_q[s][7*v+2]};
      assign ctrl_o[24*s+8*v +: 8]   = live_q[s][7*v+4];
      assign ad_o[24*s+8*v +: 8]     = live_q[s][7*v+5];
      assign sr_o[24*s+8*v +: 8]     = live_q[s][7*v+6];
    end
    assign fc_o[11*s +: 11]      = {live_q[s][22], live_q[s][21][2:0]};
    assign res_filt_o[8*s +: 8]  = live_q[s][23];
    assign mode_vol_o[8*s +: 8]  = live_q[s][24];

    logic unused_hi;
    assign unused_hi = ^{live_q[s][3][7:4], live_q[s][10][7:4],
                         live_q[s][17][7:4], live_q[s][21][7:3]};
  end
endmodule

// File: tb/tb_sid_multi_regbank.sv
// tb/tb_sid_multi_regbank.sv - directed self-checking bench for sid_multi_regbank
module tb_sid_multi_regbank;
  localparam int NS = 3;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_tick = 1'b0;
  logic [8*NS-1:0]  osc3_rd = '0;
  logic [8*NS-1:0]  env3_rd = '0;
  logic [48*NS-1:0] freq_o;
  logic [36*NS-1:0] pw_o;
  logic [24*NS-1:0] ctrl_o, ad_o, sr_o;
  logic [11*NS-1:0] fc_o;
  logic [8*NS-1:0]  res_filt_o, mode_vol_o;

  int n_vec  = 0;
  int n_miss = 0;

  sid_multi_regbank_if #(.NUM_SIDS(NS)) bus ();

  sid_multi_regbank #(.NUM_SIDS(NS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sample_tick(sample_tick),
    .osc3_rd(osc3_rd), .env3_rd(env3_rd), .freq_o(freq_o), .pw_o(pw_o),
    .ctrl_o(ctrl_o), .ad_o(ad_o), .sr_o(sr_o), .fc_o(fc_o),
    .res_filt_o(res_filt_o), .mode_vol_o(mode_vol_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] a(input int sid, input int off);
    logic [6:0] r;
    r = {sid[1:0], off[4:0]};
    return r;
  endfunction

  task automatic bus_write(input logic [6:0] addr, input logic [7:0] data, input bit tick_at_wr = 1'b0);
    bus.reg_addr = addr;
    bus.bus_in   = data;
    bus.RWb_in   = 1'b0;
    bus.CEb_in   = 1'b0;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 sample_tick = tick_at_wr;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    bus.CEb_in  = 1'b1;
    bus.RWb_in  = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [6:0] addr, input logic [7:0] exp);
    bus.reg_addr = addr;
    #1;
    check(tag, bus.bus_out, exp);
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  initial begin
    bus.CEb_in = 1'b1;
    bus.RWb_in = 1'b1;
    bus.reg_addr = '0;
    bus.bus_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 1: reset state
    check("rst_oe", bus.oe, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int o = 0; o < 29; o++)
        read_chk($sformatf("rst_rd_s%0d_o%0d", s, o), a(s, o), 8'h00);
    check("rst_freq", freq_o, '0);
    check("rst_pw", pw_o, '0);
    check("rst_ctrl_ad_sr", {ctrl_o, ad_o, sr_o}, '0);
    check("rst_filt", {fc_o, res_filt_o, mode_vol_o}, '0);

    osc3_rd = 24'h33_22_11;
    env3_rd = 24'h66_55_44;
    read_chk("osc3_s1", a(1, 27), 8'h22);
    read_chk("env3_s0", a(0, 28), 8'h44);
    read_chk("osc3_s2", a(2, 27), 8'h33);
    read_chk("osc3_bad_sel", a(3, 27), 8'h00);

    bus.reg_addr = a(0, 0);
    bus.CEb_in = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 check("oe_read", bus.oe, 1'b1);
    bus.CEb_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 check("oe_idle", bus.oe, 1'b0);

    // 2: direct writes with latency
    bus.reg_addr = a(0, 0);
    bus.bus_in = 8'h34;
    bus.RWb_in = 1'b0;
    bus.CEb_in = 1'b0;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 check("t2_lat_early", freq_o[15:0], 16'h0000);
    @(posedge clk);
    #1 check("t2_lat", freq_o[15:0], 16'h0034);
    bus.CEb_in = 1'b1;
    bus.RWb_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    bus_write(a(0, 1), 8'h12);
    check("t2_freq", freq_o[15:0], 16'h1234);
    check("t2_sid1_freq", freq_o[95:48], '0);

    bus_write(a(0, 3), 8'hFF);
    read_chk("pw_hi_rd", a(0, 3), 8'h0F);
    check("pw_hi_live", pw_o[11:0], 12'hF00);
    bus_write(a(0, 21), 8'hFF);
    read_chk("fc_lo_rd", a(0, 21), 8'h07);
    bus_write(a(0, 22), 8'hAB);
    check("fc_live", fc_o[10:0], 11'h55F);
    bus_write(a(0, 29), 8'h99);
    read_chk("off29_rd", a(0, 29), 8'h00);
    bus_write(a(0, 26), 8'hFF);
    read_chk("status_ro", a(0, 26), 8'h00);

    // 3: shadow mode and commit on SID1
    bus_write(a(1, 25), 8'h01);
    bus_write(a(1, 2), 8'hFF);
    check("t3_pw_held", pw_o[47:36], 12'h000);
    read_chk("t3_shadow_rd", a(1, 2), 8'hFF);
    read_chk("t3_status1", a(1, 26), 8'h01);
    bus_write(a(1, 25), 8'h03);
    read_chk("t3_status3", a(1, 26), 8'h03);
    read_chk("t3_sync_rd", a(1, 25), 8'h00);
    pulse_tick();
    check("t3_pw_commit", pw_o[47:36], 12'h0FF);
    read_chk("t3_status_after", a(1, 26), 8'h01);
    check("t3_sid0_pw", pw_o[11:0], 12'hF00);

    // 4: data write on the commit edge
    bus_write(a(0, 25), 8'h01);
    bus_write(a(0, 4), 8'h41);
    check("t4_ctrl_held", ctrl_o[7:0], 8'h00);
    bus_write(a(0, 25), 8'h03);
    bus_write(a(0, 4), 8'h81, 1'b1);
    check("t4_ctrl_old", ctrl_o[7:0], 8'h41);
    read_chk("t4_ctrl_shadow", a(0, 4), 8'h81);
    read_chk("t4_status", a(0, 26), 8'h01);
    read_chk("t4_sid1_status", a(1, 26), 8'h01);
    bus_write(a(0, 25), 8'h03);
    pulse_tick();
    check("t4_ctrl_new", ctrl_o[7:0], 8'h81);
    bus_write(a(0, 5), 8'h5A);
    check("t4_ad_held", ad_o[7:0], 8'h00);
    bus_write(a(0, 25), 8'h00);
    check("t4_ad_sync0", ad_o[7:0], 8'h5A);
    read_chk("t4_status0", a(0, 26), 8'h00);
    read_chk("t4_sid1_still", a(1, 26), 8'h01);

    bus_write(a(2, 25), 8'h01);
    bus_write(a(2, 23), 8'hC5);
    bus_write(a(2, 25), 8'h03, 1'b1);
    check("tick_on_sync", res_filt_o[23:16], 8'h00);
    read_chk("tick_on_sync_st", a(2, 26), 8'h03);
    pulse_tick();
    check("sid2_commit", res_filt_o[23:16], 8'hC5);

    // 5: invalid select and held write
    bus_write(a(3, 0), 8'h77);
    bus_write(a(3, 25), 8'h00);
    check("bad_sel_freq", freq_o, {48'h0, 48'h0, 48'h1234});
    read_chk("bad_sel_rd", a(3, 0), 8'h00);
    bus.reg_addr = a(0, 6);
    bus.bus_in = 8'h11;
    bus.RWb_in = 1'b0;
    bus.CEb_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.bus_in = 8'h22;
    repeat (6) @(posedge clk);
    #1 check("held_sr", sr_o[7:0], 8'h11);
    read_chk("held_rd", a(0, 6), 8'h11);
    bus.CEb_in = 1'b1;
    bus.RWb_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;

    // 6: reset mid-access with pending
    bus_write(a(1, 25), 8'h03);
    read_chk("t6_pending", a(1, 26), 8'h03);
    bus.reg_addr = a(1, 0);
    bus.bus_in = 8'h99;
    bus.RWb_in = 1'b0;
    bus.CEb_in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_status", bus.bus_out, 8'h00);
    check("t6_rst_freq", freq_o, '0);
    check("t6_rst_pw", pw_o, '0);
    read_chk("t6_rst_sid0", a(0, 0), 8'h00);
    bus.reg_addr = a(1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("t6_no_wr_live", freq_o, '0);
    read_chk("t6_no_wr_rd", a(1, 0), 8'h00);
    read_chk("t6_status", a(1, 26), 8'h00);
    bus.CEb_in = 1'b1;
    bus.RWb_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus_write(a(1, 0), 8'h99);
    check("t6_wr_after", freq_o[63:48], 16'h0099);
    read_chk("t6_rd_after", a(1, 0), 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
